// File: rtl/rtc_multitimer.sv
// ---------------------------------------------------------------------------
// rtc_multitimer
//
// Bank of NCHAN independent BCD countdown timers for the real-time clock
// core. Each channel holds an HH:MM:SS value (hours 00-99) and counts it
// down by one second every 2^LGSUBCK pulses of the shared sub-second
// strobe. On reaching zero a channel raises its sticky alarm flag and
// pulses its interrupt line for one cycle. A one-shot channel then stops.
// A periodic channel reloads its last written value and keeps running.
//
// Ports:
//   i_clk        system clock
//   i_reset_n    asynchronous active-low reset (released synchronously)
//   i_sub_ck     one-cycle sub-second strobe, 2^LGSUBCK per second
//   i_wr         one-cycle write strobe for channel i_addr
//   i_addr       channel select for both write and read-back
//   i_data       [23:0] BCD HHMMSS, [24] run, [25] periodic, rest ignored
//   o_data       registered read of channel i_addr:
//                {5'h0, periodic, alarm, running, bcd[23:0]}
//   o_interrupt  per-channel one-cycle expiry pulse
//   o_int_any    OR of all o_interrupt bits
// ---------------------------------------------------------------------------
module rtc_multitimer #(
    parameter int NCHAN   = 4,
    parameter int LGSUBCK = 2,
    parameter int AW      = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_sub_ck,
    input  logic             i_wr,
    input  logic [AW-1:0]    i_addr,
    input  logic [31:0]      i_data,
    output logic [31:0]      o_data,
    output logic [NCHAN-1:0] o_interrupt,
    output logic             o_int_any
);

    logic [1:0]       rst_sync;
    logic             rst_n;
    logic             wr_valid;
    logic [23:0]      wr_value;
    logic [NCHAN-1:0] int_vec;
    logic [31:0]      ch_word [NCHAN];
    logic [31:0]      rd_word;
    logic             unused_data_bits;

    assign wr_value         = i_data[23:0];
    assign unused_data_bits = ^i_data[31:26];

    // A written value is only accepted if every digit is legal BCD for its
    // position: seconds/minutes tens no higher than 5, all other digits no
    // higher than 9. Keeping tens digits <= 5 also keeps bits 7 and 15 clear.
    function automatic logic bcd_valid(input logic [23:0] v);
        bcd_valid = (v[3:0]   <= 4'd9) && (v[7:4]   <= 4'd5) &&
                    (v[11:8]  <= 4'd9) && (v[15:12] <= 4'd5) &&
                    (v[19:16] <= 4'd9) && (v[23:20] <= 4'd9);
    endfunction

    // One-second BCD decrement. A zero digit wraps to its maximum (5 for
    // the seconds/minutes tens, 9 otherwise) and passes the borrow upward.
    // Only ever called on a nonzero value, so the hours tens never wraps.
    function automatic logic [23:0] bcd_dec(input logic [23:0] v);
        logic [23:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (borrow) begin
                if (r[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = (i == 1 || i == 3) ? 4'd5 : 4'd9;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        bcd_dec = r;
    endfunction

    assign wr_valid = bcd_valid(wr_value);

    // Reset synchroniser: assertion reaches every flop immediately, while
    // release is lined up to a clock edge so no channel sees a partial
    // release.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    for (genvar g = 0; g < NCHAN; g++) begin : gen_chan
        logic [23:0]        bcd;
        logic [23:0]        reload;
        logic [LGSUBCK-1:0] sub;
        logic               running;
        logic               periodic;
        logic               alarm;
        logic               int_q;
        logic               tick;
        logic               expire;
        logic               wr_hit;

        // A tick is the last sub-second strobe of a running second; an
        // expiry is a tick that would take the count from 00:00:01 to zero.
        assign tick   = i_sub_ck && running && (sub == '1);
        assign expire = tick && (bcd == 24'h000001);
        assign wr_hit = i_wr && wr_valid && (i_addr == AW'(g));

        // Channel state. An expiry outranks a write landing in the same
        // cycle, so the write is dropped entirely in that case. While
        // stopped, a nonzero value loads a fresh count, a zero value resumes
        // a paused count. While running, only the run bit is honoured, which
        // lets software pause without disturbing the remaining time. Every
        // stopped-to-running start restarts the sub-second phase so the
        // first tick lands a full second later.
        always_ff @(posedge i_clk or negedge rst_n) begin
            if (!rst_n) begin
                bcd      <= '0;
                reload   <= '0;
                sub      <= '0;
                running  <= 1'b0;
                periodic <= 1'b0;
                alarm    <= 1'b0;
                int_q    <= 1'b0;
            end else begin
                int_q <= expire;
                if (running && i_sub_ck) begin
                    sub <= sub + 1'b1;
                end
                if (expire) begin
                    alarm <= 1'b1;
                    if (periodic) begin
                        bcd <= reload;
                    end else begin
                        bcd     <= '0;
                        running <= 1'b0;
                    end
                end else begin
                    if (tick) begin
                        bcd <= bcd_dec(bcd);
                    end
                    if (wr_hit) begin
                        alarm    <= 1'b0;
                        periodic <= i_data[25];
                        if (running) begin
                            running <= i_data[24];
                        end else if (wr_value != 24'h0) begin
                            bcd     <= wr_value;
                            reload  <= wr_value;
                            sub     <= '0;
                            running <= i_data[24];
                        end else if (bcd != 24'h0) begin
                            sub     <= '0;
                            running <= i_data[24];
                        end
                    end
                end
            end
        end

        assign int_vec[g] = int_q;
        assign ch_word[g] = {5'h0, periodic, alarm, running, bcd};
    end

    // Read-back select. Addresses beyond the last channel read as zero.
    always_comb begin
        rd_word = '0;
        for (int c = 0; c < NCHAN; c++) begin
            if (i_addr == AW'(c)) begin
                rd_word = ch_word[c];
            end
        end
    end

    // Registered read port, giving one cycle of latency from address to data.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            o_data <= '0;
        end else begin
            o_data <= rd_word;
        end
    end

    assign o_interrupt = int_vec;
    assign o_int_any   = |int_vec;

endmodule

// File: tb/tb_rtc_multitimer.sv
// ---------------------------------------------------------------------------
// tb_rtc_multitimer
//
// Directed self-checking bench for rtc_multitimer with NCHAN=4, LGSUBCK=2
// (four sub-second strobes per second). Inputs change on the falling edge,
// outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_rtc_multitimer;

    localparam int NCHAN   = 4;
    localparam int LGSUBCK = 2;
    localparam int AW      = 2;

    logic             i_clk;
    logic             i_reset_n;
    logic             i_sub_ck;
    logic             i_wr;
    logic [AW-1:0]    i_addr;
    logic [31:0]      i_data;
    logic [31:0]      o_data;
    logic [NCHAN-1:0] o_interrupt;
    logic             o_int_any;

    int total_checks;
    int bad_checks;

    rtc_multitimer #(
        .NCHAN   (NCHAN),
        .LGSUBCK (LGSUBCK)
    ) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_sub_ck    (i_sub_ck),
        .i_wr        (i_wr),
        .i_addr      (i_addr),
        .i_data      (i_data),
        .o_data      (o_data),
        .o_interrupt (o_interrupt),
        .o_int_any   (o_int_any)
    );

    // Free-running 10-unit clock.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total_checks++;
        if (observed !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drives one clock cycle of inputs; returns just after the rising edge.
    // The address is left in place so the read port keeps tracking it.
    task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr,
                                 input logic [31:0] data, input logic sub);
        @(negedge i_clk);
        i_wr     = wr;
        i_addr   = addr;
        i_data   = data;
        i_sub_ck = sub;
        @(posedge i_clk);
        #1;
        i_wr     = 1'b0;
        i_data   = '0;
        i_sub_ck = 1'b0;
    endtask

    task automatic idle(input logic [AW-1:0] addr);
        applyStimulus(1'b0, addr, 32'h0, 1'b0);
    endtask

    // Strobe n times, requiring no interrupt on any of them.
    task automatic quietStrobes(input int n, input logic [AW-1:0] addr, input string tag);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, addr, 32'h0, 1'b1);
            checkOutput(tag, {28'h0, o_interrupt}, 32'h0);
        end
    endtask

    initial begin
        total_checks = 0;
        bad_checks   = 0;
        i_reset_n    = 1'b0;
        i_sub_ck     = 1'b0;
        i_wr         = 1'b0;
        i_addr       = '0;
        i_data       = '0;

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        checkOutput("reset o_data", o_data, 32'h0);
        checkOutput("reset o_interrupt", {28'h0, o_interrupt}, 32'h0);
        checkOutput("reset o_int_any", {31'h0, o_int_any}, 32'h0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        repeat (3) idle(2'd0);

        // One-shot 3 s on channel 1
        applyStimulus(1'b1, 2'd1, 32'h0100_0003, 1'b0);
        quietStrobes(4, 2'd1, "ch1 quiet s1");
        idle(2'd1);
        checkOutput("ch1 bcd 2", o_data, 32'h0100_0002);
        quietStrobes(4, 2'd1, "ch1 quiet s2");
        idle(2'd1);
        checkOutput("ch1 bcd 1", o_data, 32'h0100_0001);
        quietStrobes(3, 2'd1, "ch1 quiet s3");
        applyStimulus(1'b0, 2'd1, 32'h0, 1'b1);
        checkOutput("ch1 expiry int", {28'h0, o_interrupt}, 32'h2);
        checkOutput("ch1 expiry any", {31'h0, o_int_any}, 32'h1);
        idle(2'd1);
        checkOutput("ch1 int one cycle", {28'h0, o_interrupt}, 32'h0);
        checkOutput("ch1 alarm stopped", o_data, 32'h0200_0000);

        // Periodic 2 s on channel 0
        applyStimulus(1'b1, 2'd0, 32'h0300_0002, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1'b0, 2'd0, 32'h0, 1'b1);
            checkOutput($sformatf("ch0 periodic int s%0d", i), {28'h0, o_interrupt},
                        (i == 8 || i == 16) ? 32'h1 : 32'h0);
        end
        idle(2'd0);
        checkOutput("ch0 periodic state", o_data, 32'h0700_0001);
        applyStimulus(1'b1, 2'd0, 32'h0000_0000, 1'b0);
        idle(2'd0);
        checkOutput("ch0 stop clears alarm", o_data, 32'h0000_0001);

        // Borrow chains across minutes and hours
        applyStimulus(1'b1, 2'd2, 32'h0101_0000, 1'b0);
        quietStrobes(4, 2'd2, "ch2 quiet");
        idle(2'd2);
        checkOutput("ch2 borrow 005959", o_data, 32'h0100_5959);
        applyStimulus(1'b1, 2'd3, 32'h0110_0000, 1'b0);
        quietStrobes(4, 2'd3, "ch3 quiet");
        idle(2'd3);
        checkOutput("ch3 borrow 095959", o_data, 32'h0109_5959);
        idle(2'd2);
        checkOutput("ch2 independent 005958", o_data, 32'h0100_5958);
        applyStimulus(1'b1, 2'd2, 32'h0000_0000, 1'b0);
        applyStimulus(1'b1, 2'd3, 32'h0000_0000, 1'b0);
        quietStrobes(4, 2'd3, "paused quiet");
        idle(2'd3);
        checkOutput("ch3 paused held", o_data, 32'h0009_5959);

        // Invalid BCD writes are ignored
        applyStimulus(1'b1, 2'd0, 32'h0100_0075, 1'b0);
        idle(2'd0);
        checkOutput("ch0 invalid ignored", o_data, 32'h0000_0001);
        quietStrobes(4, 2'd0, "ch0 invalid no start");
        applyStimulus(1'b1, 2'd1, 32'h0100_A000, 1'b0);
        idle(2'd1);
        checkOutput("ch1 invalid alarm kept", o_data, 32'h0200_0000);

        // Simultaneous expiry on channels 0 and 3
        applyStimulus(1'b1, 2'd0, 32'h0100_0001, 1'b0);
        applyStimulus(1'b1, 2'd3, 32'h0100_0001, 1'b0);
        quietStrobes(3, 2'd3, "dual quiet");
        applyStimulus(1'b0, 2'd3, 32'h0, 1'b1);
        checkOutput("dual expiry int", {28'h0, o_interrupt}, 32'h9);
        checkOutput("dual expiry any", {31'h0, o_int_any}, 32'h1);
        idle(2'd3);
        checkOutput("ch3 after dual", o_data, 32'h0200_0000);

        // Write colliding with expiry is discarded
        applyStimulus(1'b1, 2'd0, 32'h0100_0001, 1'b0);
        applyStimulus(1'b1, 2'd3, 32'h0100_0001, 1'b0);
        quietStrobes(3, 2'd0, "collide quiet");
        applyStimulus(1'b1, 2'd0, 32'h0300_0005, 1'b1);
        checkOutput("collide int", {28'h0, o_interrupt}, 32'h9);
        idle(2'd0);
        checkOutput("collide write dropped", o_data, 32'h0200_0000);

        // Reset while two channels run
        applyStimulus(1'b1, 2'd0, 32'h0100_0005, 1'b0);
        applyStimulus(1'b1, 2'd1, 32'h0300_0001, 1'b0);
        quietStrobes(3, 2'd0, "prereset quiet");
        applyStimulus(1'b0, 2'd0, 32'h0, 1'b1);
        checkOutput("prereset int", {28'h0, o_interrupt}, 32'h2);
        checkOutput("prereset o_data", o_data, 32'h0100_0005);
        i_reset_n = 1'b0;
        #1;
        checkOutput("midreset o_data", o_data, 32'h0);
        checkOutput("midreset o_interrupt", {28'h0, o_interrupt}, 32'h0);
        checkOutput("midreset o_int_any", {31'h0, o_int_any}, 32'h0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        repeat (3) idle(2'd0);
        quietStrobes(24, 2'd1, "postreset quiet");
        idle(2'd0);
        checkOutput("postreset ch0", o_data, 32'h0);
        idle(2'd1);
        checkOutput("postreset ch1", o_data, 32'h0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
